// File: rtl/sram_like_arbiter_pkg.sv
// Shared types for the sram-like arbiter slice: request source tags, request
// field bundle and transfer-size encodings.
package sram_like_pkg;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_like_arbiter_src_order_fifo.sv
// Issue-order FIFO of request sources; the head names the master that owns
// the next returning transaction. DEPTH must be a power of two.
module src_order_fifo
  import sram_like_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  src_e                     src_in,
  output src_e                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  src_e             slot_r [DEPTH];
  logic             push_ok_s;
  logic             pop_ok_s;

  // Overflowing pushes and underflowing pops are discarded here as well.
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Pointer, occupancy and slot storage; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_r[i] <= SRC_INST;
      end
    end else begin
      if (push_ok_s) begin
        slot_r[wr_ptr_r] <= src_in;
        wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = slot_r[rd_ptr_r];
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == CNT_W'(0));
  assign count = count_r;

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges the inst and data sram-like masters onto one slave port, routing
// each returning data_ok/rdata back to the master that issued it.
module sram_like_arbiter
  import sram_like_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          DATA_PRIORITY   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  output logic        proto_err
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic             lock_r;
  src_e             lock_src_r;
  logic             proto_err_r;
  src_e             grant_src_s;
  logic             granted_req_s;
  sram_req_t        granted_fields_s;
  logic             stall_s;
  logic             mem_req_s;
  logic             accept_s;
  logic             pop_s;
  src_e             fifo_head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CNT_W-1:0] fifo_count_s;

  // Grant selection, slave handshake pass-through and completion routing.
  always_comb begin
    grant_src_s      = SRC_INST;
    granted_req_s    = 1'b0;
    granted_fields_s = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
    if (lock_r) begin
      grant_src_s = lock_src_r;
    end else if (DATA_PRIORITY) begin
      grant_src_s = data_req ? SRC_DATA : SRC_INST;
    end else begin
      grant_src_s = inst_req ? SRC_INST : SRC_DATA;
    end
    if (grant_src_s == SRC_DATA) begin
      granted_req_s    = data_req;
      granted_fields_s = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
    end else begin
      granted_req_s    = inst_req;
    end
    // A completion arriving while full does not open a slot in the same cycle.
    stall_s   = fifo_full_s | (fifo_count_s > CNT_W'(MAX_OUTSTANDING));
    mem_req_s = ~rst & ~stall_s & granted_req_s;
    accept_s  = mem_req_s & mem_addr_ok;
    pop_s     = ~rst & mem_data_ok & ~fifo_empty_s;
  end

  // Grant lock holds the chosen master until the slave accepts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_r      <= 1'b0;
      lock_src_r  <= SRC_INST;
      proto_err_r <= 1'b0;
    end else begin
      if (mem_req_s && !mem_addr_ok) begin
        lock_r     <= 1'b1;
        lock_src_r <= grant_src_s;
      end else if (accept_s) begin
        lock_r     <= 1'b0;
      end
      if (mem_data_ok && fifo_empty_s) begin
        proto_err_r <= 1'b1;
      end
    end
  end

  src_order_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_order (
    .clk    (clk),
    .rst    (rst),
    .push   (accept_s),
    .pop    (pop_s),
    .src_in (grant_src_s),
    .head   (fifo_head_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s),
    .count  (fifo_count_s)
  );

  assign mem_req      = mem_req_s;
  assign mem_wr       = granted_fields_s.wr;
  assign mem_size     = granted_fields_s.size;
  assign mem_addr     = granted_fields_s.addr;
  assign mem_wdata    = granted_fields_s.wdata;
  assign inst_addr_ok = accept_s & (grant_src_s == SRC_INST);
  assign data_addr_ok = accept_s & (grant_src_s == SRC_DATA);
  assign inst_data_ok = pop_s & (fifo_head_s == SRC_INST);
  assign data_data_ok = pop_s & (fifo_head_s == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign proto_err    = proto_err_r;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed scenarios followed by randomized traffic, each cycle compared with
// a queue-based reference of issue order, grant hold and sticky error.
module tb_sram_like_arbiter;

  localparam int MAXO = 4;
  localparam int INST = 0;
  localparam int DATA = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok, proto_err;

  sram_like_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  // reference state
  int order_q[$];
  bit held = 1'b0;
  int held_src = INST;
  bit err_ref = 1'b0;
  // per-cycle results used by stimulus and directed checks
  bit acc_inst, acc_data;
  int done_inst_cnt, done_data_cnt;
  logic [31:0] last_inst_rdata, last_data_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Evaluate one cycle: inputs are already driven (after a negedge).
  task automatic cycle();
    bit full, greq, mreq, acc, pop;
    int g, head;
    #1;
    full = (order_q.size() >= MAXO);
    if (held) g = held_src;
    else g = data_req ? DATA : INST;
    greq = (g == DATA) ? data_req : inst_req;
    mreq = !rst && !full && greq;
    acc  = mreq && mem_addr_ok;
    pop  = !rst && mem_data_ok && (order_q.size() > 0);
    head = (order_q.size() > 0) ? order_q[0] : INST;
    chk("mem_req", mem_req, mreq);
    chk("inst_addr_ok", inst_addr_ok, acc && g == INST);
    chk("data_addr_ok", data_addr_ok, acc && g == DATA);
    chk("inst_data_ok", inst_data_ok, pop && head == INST);
    chk("data_data_ok", data_data_ok, pop && head == DATA);
    chk("proto_err", proto_err, err_ref);
    if (mreq) begin
      chk("mem_addr", mem_addr, (g == DATA) ? data_addr : inst_addr);
      chk("mem_wdata", mem_wdata, (g == DATA) ? data_wdata : inst_wdata);
      chk("mem_wr", mem_wr, (g == DATA) ? data_wr : inst_wr);
      chk("mem_size", mem_size, (g == DATA) ? data_size : inst_size);
    end
    if (pop && head == INST) chk("inst_rdata", inst_rdata, mem_rdata);
    if (pop && head == DATA) chk("data_rdata", data_rdata, mem_rdata);
    if (inst_data_ok) begin done_inst_cnt++; last_inst_rdata = inst_rdata; end
    if (data_data_ok) begin done_data_cnt++; last_data_rdata = data_rdata; end
    acc_inst = acc && g == INST;
    acc_data = acc && g == DATA;
    if (rst) begin
      order_q.delete();
      held = 1'b0;
      err_ref = 1'b0;
    end else begin
      if (mem_data_ok && order_q.size() == 0) err_ref = 1'b1;
      if (pop) void'(order_q.pop_front());
      if (acc) order_q.push_back(g);
      if (mreq && !mem_addr_ok) begin held = 1'b1; held_src = g; end
      else if (acc) held = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    cycle(); cycle();
    rst = 1'b0;

    // 1: lone inst read, data returned two cycles after accept
    done_inst_cnt = 0; done_data_cnt = 0;
    inst_req = 1'b1; inst_addr = 32'hBFC00000; mem_addr_ok = 1'b1;
    cycle();
    chk("t1_accept", {31'b0, acc_inst}, 32'd1);
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h3C010001;
    cycle();
    mem_data_ok = 1'b0;
    cycle();
    chk("t1_inst_done", done_inst_cnt, 1);
    chk("t1_data_done", done_data_cnt, 0);
    chk("t1_rdata", last_inst_rdata, 32'h3C010001);

    // 2: simultaneous requests, data wins, completions routed in issue order
    done_inst_cnt = 0; done_data_cnt = 0;
    inst_req = 1'b1; inst_addr = 32'hBFC00004;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h80000010; data_wdata = 32'h12345678;
    mem_addr_ok = 1'b1;
    cycle();
    chk("t2_data_first", {30'b0, acc_data, acc_inst}, 32'd2);
    data_req = 1'b0; data_wr = 1'b0;
    cycle();
    chk("t2_inst_next", {30'b0, acc_data, acc_inst}, 32'd1);
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'hAAAA0001;
    cycle();
    chk("t2_first_done", {done_data_cnt[15:0], done_inst_cnt[15:0]}, 32'h0001_0000);
    mem_rdata = 32'hBBBB0002;
    cycle();
    mem_data_ok = 1'b0;
    chk("t2_inst_rdata", last_inst_rdata, 32'hBBBB0002);

    // 3: slave stalls a data write for three cycles while inst rises
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h80000010; data_wdata = 32'h12345678;
    cycle();
    inst_req = 1'b1; inst_addr = 32'hBFC00008;
    cycle();
    chk("t3_hold_addr", mem_addr, 32'h80000010);
    cycle();
    mem_addr_ok = 1'b1;
    cycle();
    chk("t3_data_acc", {31'b0, acc_data}, 32'd1);
    data_req = 1'b0; data_wr = 1'b0;
    cycle();
    chk("t3_inst_acc", {31'b0, acc_inst}, 32'd1);
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    cycle(); cycle();
    mem_data_ok = 1'b0;

    // 4: five reads with no returns; fifth waits for a freed slot plus a cycle
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_addr = 32'h1000 + 32'(i * 4);
      cycle();
    end
    inst_addr = 32'h1010;
    cycle();
    chk("t4_full_req", mem_req, 1'b0);
    mem_data_ok = 1'b1;
    cycle();
    chk("t4_no_bypass", {31'b0, acc_inst}, 32'd0);
    mem_data_ok = 1'b0;
    cycle();
    chk("t4_fifth_acc", {31'b0, acc_inst}, 32'd1);
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    mem_data_ok = 1'b0;

    // 5: stray completion with nothing outstanding
    done_inst_cnt = 0; done_data_cnt = 0;
    mem_data_ok = 1'b1;
    cycle();
    mem_data_ok = 1'b0;
    cycle(); cycle();
    chk("t5_proto_err", proto_err, 1'b1);
    chk("t5_no_done", done_inst_cnt + done_data_cnt, 0);

    // 6: reset with three outstanding, then a fresh read
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    cycle(); cycle(); cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; inst_req = 1'b0; mem_addr_ok = 1'b0;
    cycle();
    chk("t6_err_clear", proto_err, 1'b0);
    done_inst_cnt = 0;
    inst_req = 1'b1; inst_addr = 32'hBFC00000; mem_addr_ok = 1'b1;
    cycle();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0BADF00D;
    cycle();
    mem_data_ok = 1'b0;
    chk("t6_fresh_done", done_inst_cnt, 1);
    chk("t6_fresh_rdata", last_inst_rdata, 32'h0BADF00D);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      mem_addr_ok = ($urandom_range(0, 2) != 0);
      mem_data_ok = (order_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      mem_rdata   = $urandom;
      rst         = ($urandom_range(0, 200) == 0);
      cycle();
      if (acc_inst || rst || !inst_req) begin
        inst_req = ($urandom_range(0, 1) == 1); inst_wr = $urandom_range(0, 1);
        inst_size = 2'($urandom_range(0, 2)); inst_addr = $urandom; inst_wdata = $urandom;
      end
      if (acc_data || rst || !data_req) begin
        data_req = ($urandom_range(0, 1) == 1); data_wr = $urandom_range(0, 1);
        data_size = 2'($urandom_range(0, 2)); data_addr = $urandom; data_wdata = $urandom;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
